// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs req/ack fetches into an instruction register,
// and drops fetches made stale by a branch redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [3:0]  cond,
   output logic [1:0]  op,
   output logic [5:0]  funct,
   output logic [3:0]  rd,
   output logic [31:0] pc_plus8,
   output logic        fault
);

   typedef enum logic [1:0] {StFetch, StDrop, StHold, StFault} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] req_addr;
   logic [31:0] ipc;
   logic [7:0]  wait_cnt;
   logic [31:0] target;
   logic        timeout;

   assign target    = {redirect_target[31:2], 2'b00};
   assign timeout   = (wait_cnt == 8'(MAX_WAIT));
   assign imem_addr = req_addr;
   assign cond      = instr[31:28];
   assign op        = instr[27:26];
   assign funct     = instr[25:20];
   assign rd        = instr[15:12];
   assign pc_plus8  = ipc + 32'd8;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= StFetch;
         pc          <= RESET_PC;
         req_addr    <= RESET_PC;
         ipc         <= RESET_PC;
         instr       <= '0;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
         fault       <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         unique case (state)
            StFetch: begin
               if (!imem_req) begin
                  // First request after reset release.
                  imem_req <= 1'b1;
                  wait_cnt <= '0;
                  if (redirect) begin
                     pc       <= target;
                     req_addr <= target;
                  end
               end else if (imem_ack) begin
                  wait_cnt <= '0;
                  if (redirect) begin
                     // Stale data: re-issue straight to the new target.
                     pc       <= target;
                     req_addr <= target;
                  end else begin
                     instr       <= imem_rdata;
                     ipc         <= req_addr;
                     instr_valid <= 1'b1;
                     pc          <= req_addr + 32'd4;
                     imem_req    <= 1'b0;
                     state       <= StHold;
                  end
               end else if (timeout) begin
                  imem_req <= 1'b0;
                  fault    <= 1'b1;
                  state    <= StFault;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
                  if (redirect) begin
                     pc    <= target;
                     state <= StDrop;
                  end
               end
            end
            StDrop: begin
               // Let the in-flight request finish on the old address, then discard it.
               if (imem_ack) begin
                  wait_cnt <= '0;
                  state    <= StFetch;
                  if (redirect) begin
                     pc       <= target;
                     req_addr <= target;
                  end else begin
                     req_addr <= pc;
                  end
               end else if (timeout) begin
                  imem_req <= 1'b0;
                  fault    <= 1'b1;
                  state    <= StFault;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
                  if (redirect) pc <= target;
               end
            end
            StHold: begin
               if (redirect) begin
                  instr_valid <= 1'b0;
                  pc          <= target;
                  req_addr    <= target;
                  imem_req    <= 1'b1;
                  wait_cnt    <= '0;
                  state       <= StFetch;
               end else if (!stall) begin
                  instr_valid <= 1'b0;
                  req_addr    <= pc;
                  imem_req    <= 1'b1;
                  wait_cnt    <= '0;
                  state       <= StFetch;
               end
            end
            StFault: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
               fault       <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small instruction memory model of selectable latency.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = '0;
   logic [31:0] instr;
   logic        instr_valid;
   logic [3:0]  cond;
   logic [1:0]  op;
   logic [5:0]  funct;
   logic [3:0]  rd;
   logic [31:0] pc_plus8;
   logic        fault;

   int          checks = 0;
   int          errors = 0;
   logic [3:0]  mem_lat = 4'd0;
   logic        ack_en = 1'b1;
   logic [3:0]  lat_cnt;

   fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ack(imem_ack), .stall(stall), .redirect(redirect),
      .redirect_target(redirect_target), .instr(instr), .instr_valid(instr_valid),
      .cond(cond), .op(op), .funct(funct), .rd(rd), .pc_plus8(pc_plus8), .fault(fault)
   );

   always #5 clk = ~clk;

   // Memory: ack after mem_lat waiting cycles; word at 4 is a known ARM instruction.
   always_comb imem_ack = ack_en && imem_req && (lat_cnt == mem_lat);
   always_comb imem_rdata = (imem_addr == 32'h4) ? 32'hE3A0_1005 : 32'h1000_0000 + imem_addr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) lat_cnt <= '0;
      else if (imem_req && !imem_ack) lat_cnt <= lat_cnt + 4'd1;
      else lat_cnt <= '0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) tick();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", imem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", instr_valid); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b exp 0", fault); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h exp 0", instr); end
      checks++; if (pc_plus8 !== 32'h8) begin errors++; $display("FAIL rst_pc8: got %h exp 8", pc_plus8); end
      reset = 1'b0;
   endtask

   task automatic test_stream();
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL st_req0: got %b/%h exp 1/0", imem_req, imem_addr); end
      tick();
      checks++; if (instr_valid !== 1'b1 || pc_plus8 !== 32'h8 || instr !== 32'h1000_0000) begin errors++; $display("FAIL st_i0: got %b/%h/%h exp 1/8/10000000", instr_valid, pc_plus8, instr); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_hold_req: got %b exp 0", imem_req); end
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin errors++; $display("FAIL st_req4: got %b/%h/%b exp 1/4/0", imem_req, imem_addr, instr_valid); end
      tick();
      checks++; if (instr_valid !== 1'b1 || pc_plus8 !== 32'hC || instr !== 32'hE3A0_1005) begin errors++; $display("FAIL st_i1: got %b/%h/%h exp 1/c/e3a01005", instr_valid, pc_plus8, instr); end
      checks++; if (cond !== 4'hE || op !== 2'b00 || funct !== 6'h3A || rd !== 4'h1) begin errors++; $display("FAIL st_fields: got %h/%h/%h/%h exp e/0/3a/1", cond, op, funct, rd); end
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL st_req8: got %b/%h exp 1/8", imem_req, imem_addr); end
      tick();
      checks++; if (instr_valid !== 1'b1 || pc_plus8 !== 32'h10) begin errors++; $display("FAIL st_i2: got %b/%h exp 1/10", instr_valid, pc_plus8); end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (instr_valid !== 1'b1 || instr !== 32'h1000_0008 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_%0d: got %b/%h/%b exp 1/10000008/0", i, instr_valid, instr, imem_req); end
      end
   endtask

   task automatic test_redirect_hold();
      redirect = 1'b1;
      redirect_target = 32'h40;
      tick();
      redirect = 1'b0;
      checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL rh_req: got %b/%b/%h exp 0/1/40", instr_valid, imem_req, imem_addr); end
      stall = 1'b0;
      tick();
      checks++; if (instr_valid !== 1'b1 || pc_plus8 !== 32'h48 || instr !== 32'h1000_0040) begin errors++; $display("FAIL rh_instr: got %b/%h/%h exp 1/48/10000040", instr_valid, pc_plus8, instr); end
   endtask

   task automatic test_latency_redirect();
      mem_lat = 4'd2;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin errors++; $display("FAIL lat_req44: got %b/%h exp 1/44", imem_req, imem_addr); end
      tick();
      redirect = 1'b1;
      redirect_target = 32'h103;
      tick();
      redirect = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h44 || instr_valid !== 1'b0) begin errors++; $display("FAIL lat_drop: got %b/%h/%b exp 1/44/0", imem_req, imem_addr, instr_valid); end
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin errors++; $display("FAIL lat_req100: got %b/%h/%b exp 1/100/0", imem_req, imem_addr, instr_valid); end
      repeat (3) tick();
      checks++; if (instr_valid !== 1'b1 || pc_plus8 !== 32'h108 || instr !== 32'h1000_0100) begin errors++; $display("FAIL lat_instr: got %b/%h/%h exp 1/108/10000100", instr_valid, pc_plus8, instr); end
   endtask

   task automatic test_wrap();
      mem_lat = 4'd0;
      redirect = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req: got %b/%h exp 1/fffffffc", imem_req, imem_addr); end
      tick();
      checks++; if (instr_valid !== 1'b1 || pc_plus8 !== 32'h4) begin errors++; $display("FAIL wrap_pc8: got %b/%h exp 1/4", instr_valid, pc_plus8); end
      ack_en = 1'b0;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %b/%h exp 1/0", imem_req, imem_addr); end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (imem_req !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL to_wait_%0d: got %b/%b exp 1/0", i, imem_req, fault); end
      end
      tick();
      checks++; if (fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL to_fault: got %b/%b/%b exp 1/0/0", fault, imem_req, instr_valid); end
      ack_en = 1'b1;
      redirect = 1'b1;
      redirect_target = 32'h80;
      tick();
      redirect = 1'b0;
      tick();
      checks++; if (fault !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL to_sticky: got %b/%b exp 1/0", fault, imem_req); end
      #2 reset = 1'b1;
      #1;
      checks++; if (fault !== 1'b0 || imem_req !== 1'b0 || pc_plus8 !== 32'h8) begin errors++; $display("FAIL to_reset: got %b/%b/%h exp 0/0/8", fault, imem_req, pc_plus8); end
      tick();
      reset = 1'b0;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL to_refetch: got %b/%h exp 1/0", imem_req, imem_addr); end
      tick();
      checks++; if (instr_valid !== 1'b1 || pc_plus8 !== 32'h8) begin errors++; $display("FAIL to_refetch_i: got %b/%h exp 1/8", instr_valid, pc_plus8); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_hold();
      test_latency_redirect();
      test_wrap();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
